// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared segment codes, digit slots, FSM states and saturation limits
package stopwatch_pkg;

  // Segment codes are stored active-low {dp,g,f,e,d,c,b,a} with dp off.
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [5:0] AN_OFF  = 6'h3F;
  localparam logic [7:0] SEG_DIGITS [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  localparam logic [2:0] DIG_MS0  = 3'd0;
  localparam logic [2:0] DIG_MS1  = 3'd1;
  localparam logic [2:0] DIG_MS2  = 3'd2;
  localparam logic [2:0] DIG_SEC0 = 3'd3;
  localparam logic [2:0] DIG_SEC1 = 3'd4;
  localparam logic [2:0] DIG_MIN  = 3'd5;

  localparam logic [11:0] MS_MAX  = 12'd999;
  localparam logic [7:0]  SEC_MAX = 8'd59;
  localparam logic [3:0]  MIN_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNAP,
    ST_CONV,
    ST_COMMIT
  } state_t;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    seg_decode = (d <= 4'd9) ? SEG_DIGITS[d] : SEG_OFF;
  endfunction

endpackage

// File: rtl/bcd_dd.sv
// rtl/bcd_dd.sv - sequential double-dabble binary to BCD converter, one bit per cycle
module bcd_dd #(
  parameter int IN_W   = 12,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       din,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int CW = $clog2(IN_W + 1);

  logic [IN_W-1:0]     bin_sh;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // done marks the cycle applying the final shift; bcd is valid from the next cycle
  assign done = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_sh <= '0;
      bcd    <= '0;
      cnt    <= '0;
    end else if (start) begin
      bin_sh <= din;
      bcd    <= '0;
      cnt    <= CW'(IN_W);
    end else if (cnt != '0) begin
      {bcd, bin_sh} <= {adj[4*DIGITS-2:0], bin_sh, 1'b0};
      cnt           <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - M SS mmm 7-segment scanner; define STOPWATCH_DISPLAY_DP_EN to show M.SS.mmm
module stopwatch_display #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] counter_ms,
  input  logic [7:0]  counter_sec,
  input  logic [3:0]  counter_min,
  output logic [7:0]  seg,
  output logic [5:0]  an,
  output logic        busy
);

  import stopwatch_pkg::*;

  localparam int            PW          = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [7:0]    SEG_OFF_LVL = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic [5:0]    AN_OFF_LVL  = AN_ACTIVE_LOW ? AN_OFF : ~AN_OFF;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          tc;
  logic          wrap;

  state_t state, state_nxt;
  logic   init_pend;
  logic   conv_start;
  logic   sec_fin;

  logic [3:0]  dig [6];
  logic [3:0]  min_snap;
  logic [11:0] ms_sat;
  logic [7:0]  sec_sat;
  logic [3:0]  min_sat;
  logic [11:0] ms_bcd;
  logic [7:0]  sec_bcd;
  logic        ms_done;
  logic        sec_done;

  logic       dp_on;
  logic [7:0] seg_lo;
  logic [5:0] an_lo;

  assign tc   = (presc == PRESC_LAST);
  assign wrap = tc && (idx == DIG_MIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      idx   <= DIG_MS0;
    end else if (tc) begin
      presc <= '0;
      idx   <= (idx == DIG_MIN) ? DIG_MS0 : idx + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign ms_sat  = (counter_ms > MS_MAX)   ? MS_MAX  : counter_ms;
  assign sec_sat = (counter_sec > SEC_MAX) ? SEC_MAX : counter_sec;
  assign min_sat = (counter_min > MIN_MAX) ? MIN_MAX : counter_min;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      init_pend <= 1'b1;
    end else begin
      state     <= state_nxt;
      init_pend <= 1'b0;
    end
  end

  // A wrap seen outside IDLE is dropped; legal SCAN_DIV keeps it from happening.
  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (init_pend || wrap) state_nxt = ST_SNAP;
      end
      ST_SNAP: begin
        conv_start = 1'b1;
        state_nxt  = ST_CONV;
      end
      ST_CONV: begin
        if (ms_done && (sec_fin || sec_done)) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  bcd_dd #(.IN_W(12), .DIGITS(3)) u_ms_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .din   (ms_sat),
    .bcd   (ms_bcd),
    .done  (ms_done)
  );

  bcd_dd #(.IN_W(8), .DIGITS(2)) u_sec_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .din   (sec_sat),
    .bcd   (sec_bcd),
    .done  (sec_done)
  );

  // All six digits update together so a scan never shows a half-written time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_fin  <= 1'b0;
      min_snap <= '0;
      for (int i = 0; i < 6; i++) dig[i] <= '0;
    end else begin
      if (state == ST_SNAP) begin
        min_snap <= min_sat;
        sec_fin  <= 1'b0;
      end else if (sec_done) begin
        sec_fin <= 1'b1;
      end
      if (state == ST_COMMIT) begin
        dig[DIG_MS0]  <= ms_bcd[3:0];
        dig[DIG_MS1]  <= ms_bcd[7:4];
        dig[DIG_MS2]  <= ms_bcd[11:8];
        dig[DIG_SEC0] <= sec_bcd[3:0];
        dig[DIG_SEC1] <= sec_bcd[7:4];
        dig[DIG_MIN]  <= min_snap;
      end
    end
  end

`ifdef STOPWATCH_DISPLAY_DP_EN
  assign dp_on = (idx == DIG_SEC0) || (idx == DIG_MIN);
`else
  assign dp_on = 1'b0;
`endif

  always_comb begin
    seg_lo = seg_decode(dig[idx]);
    if (dp_on) seg_lo[7] = 1'b0;
    an_lo = ~(6'b000001 << idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_OFF_LVL;
      an  <= AN_OFF_LVL;
    end else begin
      seg <= SEG_ACTIVE_LOW ? seg_lo : ~seg_lo;
      an  <= AN_ACTIVE_LOW ? an_lo : ~an_lo;
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - directed vector bench for stopwatch_display
`timescale 1ns/1ps
module tb_stopwatch_display;

  localparam int SD = 16;

`ifdef STOPWATCH_DISPLAY_DP_EN
  localparam logic [5:0] DP_POS = 6'b101000;
`else
  localparam logic [5:0] DP_POS = 6'b000000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] counter_ms = '0;
  logic [7:0]  counter_sec = '0;
  logic [3:0]  counter_min = '0;
  logic [7:0]  seg;
  logic [5:0]  an;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] lut [10];

  // dig nibbles ordered {min, sec tens, sec ones, ms hundreds, ms tens, ms ones}
  typedef struct packed {
    logic [11:0] ms;
    logic [7:0]  sec;
    logic [3:0]  min;
    logic [23:0] dig;
  } vec_t;

  vec_t vecs [7];

  stopwatch_display #(
    .SCAN_DIV       (SD),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .counter_ms  (counter_ms),
    .counter_sec (counter_sec),
    .counter_min (counter_min),
    .seg         (seg),
    .an          (an),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int pos, input logic [3:0] d);
    logic [7:0] s;
    s = lut[d];
    if (DP_POS[pos]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic wait_busy(input logic lvl);
    int n = 0;
    while (busy !== lvl && n < 8*SD) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic width(input string tag);
    int w = 0;
    while (busy === 1'b1 && w < 40) begin
      w++;
      @(negedge clk);
    end
    check($sformatf("%s_busy_width", tag), w, 14);
  endtask

  task automatic pulse(input string tag);
    wait_busy(1'b1);
    check($sformatf("%s_busy_rise", tag), busy, 1);
    width(tag);
  endtask

  task automatic scan(input string tag, input logic [23:0] dig);
    logic [7:0] cap [6];
    logic [5:0] m;
    for (int i = 0; i < 6; i++) cap[i] = 8'hxx;
    for (int c = 0; c < 6*SD-2; c++) begin
      for (int i = 0; i < 6; i++) begin
        m = ~(6'b000001 << i);
        if (an === m) cap[i] = seg;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_dig%0d", tag, i), cap[i], exp_seg(i, dig[4*i +: 4]));
  endtask

  task automatic slot_timing();
    logic [5:0] prev;
    logic [5:0] m;
    logic       pb;
    int         n;
    int         cur;
    int         rises;
    prev = an;
    n = 0;
    while (an === prev && n < 2*SD) begin
      @(negedge clk);
      n++;
    end
    rises = 0;
    pb = busy;
    for (int k = 0; k < 12; k++) begin
      cur = -1;
      for (int i = 0; i < 6; i++) begin
        m = ~(6'b000001 << i);
        if (an === m) cur = i;
      end
      m = ~(6'b000001 << ((cur + 1) % 6));
      prev = an;
      n = 0;
      while (an === prev && n < 2*SD) begin
        @(negedge clk);
        n++;
        if (busy === 1'b1 && pb !== 1'b1) rises++;
        pb = busy;
      end
      check($sformatf("slot%0d_interval", k), n, SD);
      check($sformatf("slot%0d_an", k), an, m);
    end
    check("busy_pulses_2frames", rises, 2);
  endtask

  initial begin
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    vecs[0] = '{ms: 12'd0,    sec: 8'd0,   min: 4'd0,  dig: 24'h000000};
    vecs[1] = '{ms: 12'd789,  sec: 8'd45,  min: 4'd3,  dig: 24'h345789};
    vecs[2] = '{ms: 12'd1000, sec: 8'd60,  min: 4'd10, dig: 24'h959999};
    vecs[3] = '{ms: 12'd4095, sec: 8'd255, min: 4'd15, dig: 24'h959999};
    vecs[4] = '{ms: 12'd999,  sec: 8'd59,  min: 4'd9,  dig: 24'h959999};
    vecs[5] = '{ms: 12'd506,  sec: 8'd30,  min: 4'd0,  dig: 24'h030506};
    vecs[6] = '{ms: 12'd10,   sec: 8'd9,   min: 4'd1,  dig: 24'h109010};

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_seg", seg, 8'hFF);
    check("reset_an", an, 6'h3F);
    check("reset_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("init_trigger", busy, 1);
    width("init");
    scan("init", 24'h000000);

    slot_timing();

    for (int v = 0; v < 7; v++) begin
      wait_busy(1'b0);
      counter_ms  = vecs[v].ms;
      counter_sec = vecs[v].sec;
      counter_min = vecs[v].min;
      pulse($sformatf("vec%0d", v));
      scan($sformatf("vec%0d", v), vecs[v].dig);
    end

    wait_busy(1'b0);
    counter_ms  = 12'd123;
    counter_sec = 8'd0;
    counter_min = 4'd0;
    wait_busy(1'b1);
    check("midconv_rise", busy, 1);
    repeat (5) @(negedge clk);
    counter_ms = 12'd456;
    wait_busy(1'b0);
    check("midconv_fall", busy, 0);
    scan("midconv_old", 24'h000123);
    wait_busy(1'b0);
    pulse("midconv_next");
    scan("midconv_new", 24'h000456);

    wait_busy(1'b0);
    counter_ms  = 12'd321;
    counter_sec = 8'd12;
    counter_min = 4'd4;
    wait_busy(1'b1);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_seg", seg, 8'hFF);
    check("abort_an", an, 6'h3F);
    check("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_retrigger", busy, 1);
    width("abort");
    scan("abort", 24'h412321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
